// File: rtl/npu_chain_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | npu_chain_pkg                                                        |
// | Shared state type and count-width helper for the chain loader.       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package npu_chain_pkg;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    // Bits needed to hold 0..depth inclusive; never less than one.
    function automatic int count_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/chain_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | chain_loader                                                         |
// | Shifts input vectors into a DEPTH-stage chain and presents the whole |
// | chain as one batch snapshot with a valid/ready handshake.           |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module chain_loader
    import npu_chain_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int LANES  = 4,
    parameter int DEPTH  = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     i_valid,
    output logic                                     i_ready,
    input  logic                                     i_last,
    input  logic [0:LANES-1][DWIDTH-1:0]             i_data,
    output logic                                     o_valid,
    input  logic                                     o_ready,
    output logic [0:DEPTH-1][0:LANES-1][DWIDTH-1:0]  o_data,
    output logic [count_width(DEPTH)-1:0]            o_count,
    input  logic                                     i_flush
);

    localparam int            CW      = count_width(DEPTH);
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);
    localparam logic [CW-1:0] c_one   = CW'(1);

    state_t                                     r_state;
    state_t                                     w_next_state;
    logic [CW-1:0]                              r_count;
    logic [CW-1:0]                              w_next_count;
    logic                                       r_run;
    logic                                       w_ready;
    logic                                       w_accept;
    logic [0:DEPTH-1][0:LANES-1][DWIDTH-1:0]    r_stage;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= FILL;
            r_count <= '0;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_next_count;
            r_run   <= 1'b1;
        end
    end

    // r_run keeps i_ready low until the first edge after reset release.
    always_comb begin
        w_ready      = r_run && !i_flush && ((r_state == FILL) || o_ready);
        w_accept     = i_valid && w_ready;
        w_next_state = r_state;
        w_next_count = r_count;
        if (i_flush) begin
            w_next_state = FILL;
            w_next_count = '0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        w_next_count = r_count + c_one;
                        if ((w_next_count == c_depth) || i_last) begin
                            w_next_state = FULL;
                        end
                    end
                end
                FULL: begin
                    if (o_ready) begin
                        if (w_accept) begin
                            w_next_count = c_one;
                            w_next_state = ((c_depth == c_one) || i_last) ? FULL : FILL;
                        end else begin
                            w_next_count = '0;
                            w_next_state = FILL;
                        end
                    end
                end
                default: begin
                    w_next_state = FILL;
                    w_next_count = '0;
                end
            endcase
        end
    end

    // Stage 0 is the newest vector; older ones move toward DEPTH-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stage <= '0;
        end else if (w_accept) begin
            r_stage[0] <= i_data;
            for (int k = 1; k < DEPTH; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    assign i_ready = w_ready;
    assign o_valid = (r_state == FULL);
    assign o_data  = r_stage;
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: doc/chain_loader.md
CHAIN_LOADER -- requirements
Module: chain_loader

Interface
REQ-001 Parameters SHALL be: DWIDTH, default 8, lane width in bits; LANES, default 4, lanes per vector; DEPTH, default 4, vectors per batch, minimum 1.
REQ-002 Clock/reset SHALL be: one clock; reset is asynchronous and active-low. Ports: clk (in, 1, rising-edge clock); rst (in, 1, asynchronous active-low reset).
REQ-003 Input-side ports SHALL be:
- i_valid (in, 1): input vector valid.
- i_ready (out, 1): loader accepts a vector.
- i_last (in, 1): vector closes a batch early.
- i_data (in, DWIDTH x [0:LANES-1]): input vector.
REQ-004 Output-side ports SHALL be:
- o_valid (out, 1): batch snapshot valid.
- o_ready (in, 1): consumer takes the batch.
- o_data (out, DWIDTH x [0:DEPTH-1][0:LANES-1]): stage snapshot.
- o_count (out, CW = clog2(DEPTH+1)): vectors in the batch.
REQ-005 i_flush (in, 1) SHALL discard the partial batch.

Function
REQ-006 A vector SHALL be accepted on a rising edge with i_valid && i_ready; i_data is sampled only then.
REQ-007 Acceptance SHALL shift all stages one position: stage 0 <= i_data, stage k <= stage k-1, per lane independently; stage 0 is the newest.
REQ-008 Stages SHALL hold their value on every cycle without acceptance.
REQ-009 The FSM SHALL have two states: FILL (i_ready=1, o_valid=0) and FULL (o_valid=1).
REQ-010 FILL SHALL go to FULL on the acceptance that makes count == DEPTH or carries i_last=1; o_count then equals the vectors accepted in the batch.
REQ-011 In FULL, o_data and o_count SHALL stay stable until o_valid && o_ready.
REQ-012 In FULL, i_ready SHALL equal o_ready, so a vector is accepted only in the cycle the batch drains (back-to-back).
REQ-013 Drain without acceptance SHALL go to FILL with count=0.
REQ-014 Drain with acceptance SHALL start a new batch with count=1, going to FILL, or to FULL if DEPTH==1 or i_last=1.
REQ-015 Latency SHALL be: o_valid rises on the edge after the closing acceptance (1 cycle); there are no bubbles between batches.
REQ-016 i_flush SHALL force count=0 and FILL, ignore i_valid that cycle (i_ready=0 while i_flush=1) and override drain/accept; stage contents are not cleared.
REQ-017 i_last on the DEPTH-th vector SHALL be equivalent to a normal full batch.
REQ-018 Stages of a partial batch (count < DEPTH) at index >= o_count SHALL hold prior, don't-care data.
REQ-019 The count SHALL never exceed DEPTH and SHALL never wrap.
REQ-020 Outputs SHALL be registered or derived from state only, with no combinational path from i_valid to o_valid.

Reset
REQ-021 rst=0 SHALL asynchronously force FILL, count=0, and all stage registers to 0.
REQ-022 Output values during reset SHALL be: o_valid=0, o_count=0, o_data=all zero, i_ready=0.
REQ-023 i_ready SHALL go to 1 on the first clk edge after rst deasserts.
REQ-024 Reset mid-batch or in FULL SHALL discard the batch with no partial output.

Structure
REQ-025 Package npu_chain_pkg SHALL hold the state enum typedef (FILL, FULL) and a count-width helper constant function.
REQ-026 The stage datapath SHALL be inline with asynchronous reset; the existing synchronous-reset chain module SHALL NOT be instantiated.
REQ-027 There SHALL be no other sub-module.

Verification (DWIDTH=8, LANES=2, DEPTH=4)
REQ-028 Reset, then 4 vectors {1,2,3,4} with o_ready=0 -> o_valid on the edge after the 4th; o_data[0..3]={4,3,2,1}; o_count=4; i_ready=0; held 10 cycles.
REQ-029 Continuous i_valid and o_ready=1, 12 vectors -> 3 batches, no idle cycle, each o_count=4, correct order.
REQ-030 i_last on the 2nd vector {9,10} -> o_count=2, o_data[0]=10, o_data[1]=9.
REQ-031 i_flush after 3 vectors, then 4 new -> batch of only the new 4, o_count=4.
REQ-032 rst pulse in FULL -> o_valid=0, o_data=0 immediately, with no clock edge needed.
REQ-033 Random i_valid/o_ready/i_last at 30% density -> a scoreboard matches every batch; o_data is stable while o_valid && !o_ready.
